// File: rtl/except_ctrl.sv
// Exception commit controller (MEM stage): picks the highest-priority cause, strobes the CP0
// update and owns the flush/redirect handshake. Optional `EXC_PERF_CNT_EN adds event counters.
module except_ctrl #(
  parameter logic [31:0] EXC_VECTOR  = 32'hBFC00380,
  parameter int          BIT_INT     = 0,
  parameter int          BIT_ADEL_IF = 1,
  parameter int          BIT_RI      = 10,
  parameter int          BIT_OV      = 12,
  parameter int          BIT_SYS     = 8,
  parameter int          BIT_BP      = 9,
  parameter int          BIT_ADEL_D  = 4,
  parameter int          BIT_ADES    = 5,
  parameter int          BIT_ERET    = 13
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [31:0] mem_excepttype,
  input  logic [31:0] mem_pc,
  input  logic        mem_in_delay_slot,
  input  logic [31:0] mem_badvaddr,
  input  logic        int_pending,
  input  logic        status_exl,
  input  logic [31:0] cp0_epc,
  input  logic        flush_ack,
  output logic        flush_o,
  output logic [31:0] flush_pc_o,
  output logic        exc_commit_o,
  output logic [4:0]  exc_code_o,
  output logic [31:0] exc_epc_o,
  output logic        exc_bd_o,
  output logic        exc_badvaddr_we_o,
  output logic [31:0] exc_badvaddr_o,
  output logic        eret_commit_o,
  output logic        busy_o
`ifdef EXC_PERF_CNT_EN
  ,
  output logic [31:0] exc_count_o,
  output logic [31:0] int_count_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_COMMIT, S_FLUSH, S_DRAIN} state_t;

  state_t      state, state_next;
  logic        int_hit, trigger;
  logic        sel_eret, sel_bva_we;
  logic [4:0]  sel_code;
  logic [31:0] sel_bva;
  logic        is_eret_q, bva_we_q;

  // The interrupt marker bit is informational only; interrupts come from int_pending.
  logic unused_bits;
  assign unused_bits = ^{mem_excepttype, mem_excepttype[BIT_INT]};

  always_comb begin : cause_select
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    int_hit    = int_pending && !status_exl;
    sel_code   = 5'd0;
    sel_bva_we = 1'b0;
    sel_bva    = '0;
    sel_eret   = 1'b0;
    if (int_hit) begin
      sel_code = 5'd0;
    end else if (mem_excepttype[BIT_ADEL_IF]) begin
      sel_code   = 5'd4;
      sel_bva_we = 1'b1;
      sel_bva    = mem_pc;
    end else if (mem_excepttype[BIT_RI]) begin
      sel_code = 5'd10;
    end else if (mem_excepttype[BIT_OV]) begin
      sel_code = 5'd12;
    end else if (mem_excepttype[BIT_SYS]) begin
      sel_code = 5'd8;
    end else if (mem_excepttype[BIT_BP]) begin
      sel_code = 5'd9;
    end else if (mem_excepttype[BIT_ADEL_D]) begin
      sel_code   = 5'd4;
      sel_bva_we = 1'b1;
      sel_bva    = mem_badvaddr;
    end else if (mem_excepttype[BIT_ADES]) begin
      sel_code   = 5'd5;
      sel_bva_we = 1'b1;
      sel_bva    = mem_badvaddr;
    end else if (mem_excepttype[BIT_ERET]) begin
      sel_eret = 1'b1;
    end
    trigger = mem_valid && (int_hit || |{mem_excepttype[BIT_ADEL_IF], mem_excepttype[BIT_RI],
                                         mem_excepttype[BIT_OV], mem_excepttype[BIT_SYS],
                                         mem_excepttype[BIT_BP], mem_excepttype[BIT_ADEL_D],
                                         mem_excepttype[BIT_ADES], mem_excepttype[BIT_ERET]});
  end

  always_ff @(posedge clk or negedge resetn) begin : state_reg
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!resetn) state <= S_IDLE;
    else         state <= state_next;
  end

  always_comb begin : next_state
    state_next = state;
    case (state)
      S_IDLE:   if (trigger) state_next = S_COMMIT;
      S_COMMIT: state_next = S_FLUSH;
      S_FLUSH:  if (flush_ack) state_next = S_DRAIN;
      S_DRAIN:  state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Captured data is held until the next trigger so CP0 can sample it in COMMIT.
  always_ff @(posedge clk or negedge resetn) begin : capture
    if (!resetn) begin
      exc_code_o     <= '0;
      exc_epc_o      <= '0;
      exc_bd_o       <= 1'b0;
      exc_badvaddr_o <= '0;
      bva_we_q       <= 1'b0;
      is_eret_q      <= 1'b0;
      flush_pc_o     <= '0;
    end else if (state == S_IDLE && trigger) begin
      exc_code_o     <= sel_code;
      exc_epc_o      <= mem_in_delay_slot ? mem_pc - 32'd4 : mem_pc;
      exc_bd_o       <= mem_in_delay_slot;
      exc_badvaddr_o <= sel_bva;
      bva_we_q       <= sel_bva_we;
      is_eret_q      <= sel_eret;
      flush_pc_o     <= sel_eret ? cp0_epc : EXC_VECTOR;
    end
  end

  always_comb begin : outputs
    flush_o           = (state == S_COMMIT) || (state == S_FLUSH);
    exc_commit_o      = (state == S_COMMIT) && !is_eret_q;
    eret_commit_o     = (state == S_COMMIT) && is_eret_q;
    exc_badvaddr_we_o = (state == S_COMMIT) && !is_eret_q && bva_we_q;
    busy_o            = (state != S_IDLE);
  end

`ifdef EXC_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin : perf_cnt
    if (!resetn) begin
      exc_count_o <= '0;
      int_count_o <= '0;
    end else if (state == S_COMMIT && !is_eret_q) begin
      exc_count_o <= exc_count_o + 32'd1;
      if (exc_code_o == 5'd0) int_count_o <= int_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- Exception commit controller in the MEM stage.
- Takes the per-instruction 32-bit exception vector built by the ID-stage detection logic, together with the masked pending interrupt from CP0.
- Selects the highest-priority cause and sequences the CP0 update (Cause/EPC/BadVAddr/EXL) and the pipeline flush/redirect through a flush handshake with the fetch unit.
- Sole owner of the flush/redirect resource for exceptions and ERET.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect PC for all exceptions and interrupts.
- BIT_INT, 0, excepttype bit index: interrupt marker (unused input bit; interrupt comes from int_pending).
- BIT_ADEL_IF, 1, excepttype bit index: instruction-fetch address error.
- BIT_RI, 10, excepttype bit index: reserved instruction.
- BIT_OV, 12, excepttype bit index: arithmetic overflow.
- BIT_SYS, 8, excepttype bit index: syscall.
- BIT_BP, 9, excepttype bit index: break.
- BIT_ADEL_D, 4, excepttype bit index: load address error.
- BIT_ADES, 5, excepttype bit index: store address error.
- BIT_ERET, 13, excepttype bit index: eret.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- mem_valid  in  1  MEM stage holds a real (non-bubble) instruction
- mem_excepttype  in  32  exception vector of MEM instruction
- mem_pc  in  32  PC of MEM instruction
- mem_in_delay_slot  in  1  MEM instruction is in a branch delay slot
- mem_badvaddr  in  32  faulting data address (AdEL_D/AdES)
- int_pending  in  1  CP0 interrupt request, already masked by IM/IE
- status_exl  in  1  CP0 Status.EXL
- cp0_epc  in  32  current CP0 EPC
- flush_ack  in  1  fetch unit accepted redirect
- flush_o  out  1  flush all stages up to MEM, redirect fetch
- flush_pc_o  out  32  redirect target
- exc_commit_o  out  1  one-cycle CP0 write strobe (Cause.ExcCode, Cause.BD, EPC, set EXL)
- exc_code_o  out  5  ExcCode for CP0
- exc_epc_o  out  32  EPC value for CP0
- exc_bd_o  out  1  Cause.BD value
- exc_badvaddr_we_o  out  1  BadVAddr write strobe, coincident with exc_commit_o
- exc_badvaddr_o  out  32  BadVAddr value
- eret_commit_o  out  1  one-cycle strobe: CP0 clears EXL
- busy_o  out  1  controller not IDLE; MEM must not retire

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0; captured registers 0. Assertion mid-sequence aborts it immediately with no strobe.
- Trigger is evaluated in IDLE only: mem_valid && (any enabled cause bit || (int_pending && !status_exl)). When mem_valid=0, the trigger is ignored.
- Priority, high to low, with ExcCode:
  - Int 0
  - AdEL_IF 4 (badvaddr = mem_pc)
  - RI 10
  - Ov 12
  - Sys 8
  - Bp 9
  - AdEL_D 4 (badvaddr = mem_badvaddr)
  - AdES 5 (badvaddr = mem_badvaddr)
  - ERET
- Any exception cause beats a co-present ERET.
- Capture on the trigger clock edge:
  - code
  - EPC = mem_in_delay_slot ? mem_pc-4 : mem_pc (32-bit wrap)
  - BD
  - badvaddr and its write-enable
  - is_eret
  - target = is_eret ? cp0_epc : EXC_VECTOR
- FSM:
  - IDLE -> COMMIT on trigger.
  - COMMIT (1 cycle):
    - exception: exc_commit_o=1, plus exc_badvaddr_we_o=1 for address errors.
    - ERET: eret_commit_o=1.
    - flush_o=1.
    - -> FLUSH.
  - FLUSH: flush_o=1 and flush_pc_o stable until flush_ack=1 is sampled; then -> DRAIN. flush_ack may already be high in COMMIT; it is only sampled in FLUSH, so the minimum flush_o width is 2 cycles.
  - DRAIN (1 cycle): flush_o=0 -> IDLE.
- busy_o=1 in COMMIT/FLUSH/DRAIN.
- Triggers arriving while not IDLE are dropped (the instruction is being flushed).
- exc_* data outputs hold their captured values from COMMIT until the next capture.
- Strobes are exactly one cycle; no strobe is ever issued outside COMMIT.
- ERET while status_exl=0 still executes (target = cp0_epc).

Optional Feature:
- Macro: EXC_PERF_CNT_EN.
- Defined:
  - Adds outputs exc_count_o[31:0] and int_count_o[31:0].
  - Both reset to 0 and wrap at 2^32.
  - exc_count_o increments in each COMMIT cycle of a non-ERET entry; int_count_o also increments when code=0.
- Undefined: ports and logic absent; otherwise identical behaviour.

Test Plan:
- Reset, then mem_valid=1 with only bit BIT_SYS set, mem_pc=0x80001000, no delay slot, flush_ack tied 1 -> COMMIT cycle: exc_commit_o=1, exc_code_o=8, exc_epc_o=0x80001000, flush_pc_o=0xBFC00380. flush_o high 2 cycles; busy_o high 3 cycles.
- BIT_RI and BIT_OV set, mem_in_delay_slot=1, mem_pc=0x80000014 -> exc_code_o=10, exc_bd_o=1, exc_epc_o=0x80000010.
- BIT_ADES set, mem_badvaddr=0x00000003 -> exc_code_o=5, exc_badvaddr_we_o=1 with exc_badvaddr_o=0x00000003, concurrent with exc_commit_o.
- BIT_ERET only, cp0_epc=0x80002000, flush_ack delayed 4 cycles -> eret_commit_o one pulse, exc_commit_o=0, flush_o held 5 cycles with flush_pc_o=0x80002000.
- int_pending=1 and status_exl=0 with BIT_BP set -> exc_code_o=0. Repeat with status_exl=1 -> exc_code_o=9. Repeat with mem_valid=0 -> no action.
- Second trigger during FLUSH -> ignored. resetn pulled low in FLUSH -> flush_o=0 immediately, IDLE, no strobe after release.
